// File: rtl/counter_arbiter_ctrl_if.sv
// Two-requester ownership bus plus count-pulse outputs for counter_arbiter_ctrl.
interface counter_arbiter_ctrl_if;
    logic [1:0] req;
    logic [1:0] cmd0;
    logic [1:0] cmd1;
    logic [4:0] counter_num;
    logic [1:0] grant;
    logic       enable;
    logic       up_down;
    logic       busy;

    modport slave  (input  req, cmd0, cmd1, counter_num,
                    output grant, enable, up_down, busy);
    modport master (output req, cmd0, cmd1, counter_num,
                    input  grant, enable, up_down, busy);
endinterface

// File: rtl/counter_arbiter_ctrl.sv
// Round-robin owner arbiter driving prescaled enable/up_down pulses to a modulo counter.
// Optional sweep (bounce between 0 and COUNT_MAX-1) is built when SWEEP_MODE_EN is defined.
module counter_arbiter_ctrl #(
    parameter int DIV_MAX   = 25_000_000,
    parameter int COUNT_MAX = 16
) (
    input logic                   clk,
    input logic                   rst_n_a,
    counter_arbiter_ctrl_if.slave bus
);
    localparam int              PW       = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(DIV_MAX - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HOLD     = 3'd1,
        UP       = 3'd2,
        DOWN     = 3'd3
`ifdef SWEEP_MODE_EN
        ,
        SWEEP_UP = 3'd4,
        SWEEP_DN = 3'd5
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic            enable_q, enable_d;
    logic            up_q, up_d;
    logic            ptr_q, ptr_d;
    logic [PW-1:0]   presc_q, presc_d;

    logic            tick;
    logic            owner_drop;
    logic            win1;

    function automatic state_t cmd_state(input logic [1:0] c);
        case (c)
            2'b01:   return UP;
            2'b10:   return DOWN;
`ifdef SWEEP_MODE_EN
            2'b11:   return SWEEP_UP;
`endif
            default: return HOLD;
        endcase
    endfunction

`ifdef SWEEP_MODE_EN
    logic num_over, num_top, num_bot;
    assign num_over = {1'b0, bus.counter_num} >= 6'(COUNT_MAX);
    assign num_top  = bus.counter_num == 5'(COUNT_MAX - 1);
    assign num_bot  = bus.counter_num == 5'd0;
`else
    logic unused_num;
    assign unused_num = ^bus.counter_num;
`endif

    assign tick       = (presc_q == PRE_LAST);
    assign owner_drop = (state_q != IDLE) && ((grant_q & bus.req) == 2'b00);
    // ptr_q=0 favours req[0]; ptr_q=1 favours req[1]
    assign win1       = ptr_q ? bus.req[1] : ~bus.req[0];

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        enable_d = 1'b0;
        up_d     = up_q;
        ptr_d    = ptr_q;
        presc_d  = tick ? '0 : presc_q + 1'b1;

        if (state_q == IDLE) begin
            if (|bus.req) begin
                grant_d = win1 ? 2'b10 : 2'b01;
                state_d = cmd_state(win1 ? bus.cmd1 : bus.cmd0);
                presc_d = '0;
            end
        end else if (owner_drop) begin
            // release beats a coincident tick: no pulse on the way out
            state_d = IDLE;
            grant_d = 2'b00;
            ptr_d   = ~ptr_q;
        end else if (tick) begin
            case (state_q)
                UP: begin
                    enable_d = 1'b1;
                    up_d     = 1'b1;
                end
                DOWN: begin
                    enable_d = 1'b1;
                    up_d     = 1'b0;
                end
`ifdef SWEEP_MODE_EN
                SWEEP_UP: begin
                    enable_d = 1'b1;
                    if (num_over || num_top) begin
                        state_d = SWEEP_DN;
                        up_d    = 1'b0;
                    end else begin
                        up_d    = 1'b1;
                    end
                end
                SWEEP_DN: begin
                    enable_d = 1'b1;
                    if (!num_over && num_bot) begin
                        state_d = SWEEP_UP;
                        up_d    = 1'b1;
                    end else begin
                        up_d    = 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            state_q  <= IDLE;
            grant_q  <= 2'b00;
            enable_q <= 1'b0;
            up_q     <= 1'b0;
            ptr_q    <= 1'b0;
            presc_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            enable_q <= enable_d;
            up_q     <= up_d;
            ptr_q    <= ptr_d;
            presc_q  <= presc_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.enable  = enable_q;
    assign bus.up_down = up_q;
    assign bus.busy    = (state_q != IDLE);
endmodule
